ipsl_pcie_dma_tx_arb: RTL and testbench
=======================================

// Module: ipsl_pcie_dma_tx_arb
// PURPOSE
//  Downstream of the DMA TX top. Merges its three AXI-stream TLP channels into the single TX stream of the PCIe core:
//  ch0 = CPLD, ch1 = MRD, ch2 = MWR.
//  Arbitration is TLP-atomic: a grant holds from the first beat of a TLP until its tlast beat.
//  The output is a 2-entry skid buffer. Per-channel TLP counters are kept for debug.
// PARAMETERS
//  DATA_WIDTH     128  TLP beat width (tdata)
//  CPLD_PRIORITY  1    1: ch0 wins every arbitration it requests; 0: pure round-robin
//  CNT_WIDTH      16   width of each per-channel TLP counter
// PORTS
//  clk                 in   1           user clock (gen1 62.5MHz, gen2 125MHz)
//  rst                 in   1           synchronous, active-high reset
//  i_axis_slave0_tvld  in   1           ch0 (CPLD) beat valid; same set for slave1 (MRD), slave2 (MWR)
//  i_axis_slave0_tdata in   DATA_WIDTH  ch0 beat data
//  i_axis_slave0_tlast in   1           ch0 last beat of TLP
//  i_axis_slave0_tuser in   1           ch0 per-beat sideband, passed through unchanged
//  o_axis_slave0_trdy  out  1           ch0 ready
//  o_axis_tx_tvld      out  1           merged stream valid
//  o_axis_tx_tdata     out  DATA_WIDTH  merged stream data
//  o_axis_tx_tlast     out  1           merged stream last beat
//  o_axis_tx_tuser     out  1           merged stream sideband
//  i_axis_tx_trdy      in   1           core ready
//  i_tx_restart        in   1           clear TLP counters
//  o_grant             out  3           one-hot current grant; 0 when IDLE
//  o_tlp_cnt           out  3*CNT_WIDTH TLPs accepted per channel; ch0 in bits [CNT_WIDTH-1:0]
// BEHAVIOUR
//  Reset: all of the following are 0 and remain 0 while rst=1:
//   - o_axis_tx_tvld/tdata/tlast/tuser, o_axis_slaveN_trdy, o_grant, o_tlp_cnt
//   - FSM = IDLE, round-robin pointer = ch0, skid buffer empty
//   Reset mid-TLP discards skid contents and the partial TLP. No tlast is fabricated.
//  FSM IDLE:
//   - All slave trdy = 0.
//   - If any tvld=1, register the winner into o_grant and go to XFER next cycle.
//   - Cost: one bubble cycle per TLP.
//  Winner selection:
//   - CPLD_PRIORITY=1 and ch0 valid -> ch0.
//   - Otherwise the first valid channel at or after the pointer (ptr, ptr+1, ptr+2 mod 3).
//  FSM XFER:
//   - Granted o_axis_slaveN_trdy = ~skid_full; the other channels' trdy = 0.
//   - A beat is accepted when tvld & trdy; it is pushed into the skid with tdata/tlast/tuser.
//   - On an accepted tlast: go to IDLE, o_grant <= 0, pointer <= granted+1 mod 3.
//   - tvld dropping mid-TLP keeps the grant. No timeout.
//  Skid buffer: 2 entries, FIFO order.
//   - o_axis_tx_tvld = (count != 0); head drives tdata/tlast/tuser.
//   - Pop on tvld & i_axis_tx_trdy. Push and pop in the same cycle leave count unchanged.
//   - skid_full = (count == 2). Push when full is impossible by construction; assert in sim.
//   - Latency: 1 cycle from input accept to o_axis_tx_tvld when empty.
//   - Sustained 1 beat/clk within a TLP while i_axis_tx_trdy = 1.
//   - Output holds data/last/user stable while tvld & ~trdy (AXI-stream rule).
//  Counters:
//   - Per-channel count += 1 on an accepted input tlast beat.
//   - Saturate at all-ones (no wrap).
//   - i_tx_restart clears all three counters the next cycle and wins over a simultaneous increment.
//  Single-beat TLP (tlast on the first beat): legal; IDLE->XFER->IDLE, 2 cycles per TLP.
// STRUCTURE
//  - Shared include ipsl_pcie_dma_define.vh: channel index constants CH_CPLD=0, CH_MRD=1, CH_MWR=2; FSM encodings.
//  - Sub-module ipsl_pcie_dma_tx_skid: 2-entry AXI-stream skid buffer, width DATA_WIDTH+2.
//  - Top holds FSM, arbiter, pointer, counters.
// TESTING
//  - Reset: drive all tvld=1 with rst=1 -> all trdy=0, o_axis_tx_tvld=0, counters 0.
//    Release rst -> first grant is ch0 (3'b001).
//  - Round-robin, CPLD_PRIORITY=0: all channels hold continuous 4-beat TLPs, trdy=1.
//    -> output order ch0,ch1,ch2,ch0...; no interleaved beats; each TLP = 5 cycles incl. bubble.
//  - Priority, CPLD_PRIORITY=1: ch0 and ch2 both always valid -> ch2 is never granted.
//    Drop ch0 -> ch2 is granted on the next IDLE.
//  - Backpressure: 8-beat MWR TLP, i_axis_tx_trdy toggles 1,0,0,1...
//    -> output beats identical and in order, no drop/duplicate, slave2 trdy=0 whenever the skid is full.
//  - Counters: 3 CPLD TLPs, then i_tx_restart in the same cycle as a 4th tlast -> cnt0 = 0.
//    With CNT_WIDTH=2, 5 TLPs -> cnt0 = 3.
//  - Reset mid-TLP at beat 2 of 4 -> o_axis_tx_tvld=0 the next cycle.
//    The next TLP after release emerges intact, starting at its first beat.

Source files
------------

// File: rtl/ipsl_pcie_dma_tx_arb_pkg.sv
// Shared definitions for the PCIe DMA TX arbiter: channel indices, FSM states and
// arbitration helpers.
package ipsl_pcie_dma_tx_arb_pkg;

    localparam int NUM_CH = 3;

    localparam logic [1:0] CH_CPLD = 2'd0;
    localparam logic [1:0] CH_MRD  = 2'd1;
    localparam logic [1:0] CH_MWR  = 2'd2;

    typedef enum logic {StIdle, StXfer} arb_state_e;

    // One-hot winner: CPLD first when prioritised, else first requester at or after ptr.
    function automatic logic [2:0] pick_winner(logic [2:0] vld, logic [1:0] ptr, logic prio);
        logic found;
        int   j;
        pick_winner = '0;
        found       = 1'b0;
        if (prio && vld[CH_CPLD]) begin
            pick_winner[CH_CPLD] = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                j = int'(ptr) + k;
                if (j >= NUM_CH) j = j - NUM_CH;
                if (!found && vld[j]) begin
                    pick_winner[j] = 1'b1;
                    found          = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [1:0] next_ptr(logic [2:0] grant);
        if (grant[CH_CPLD]) return CH_MRD;
        else if (grant[CH_MRD]) return CH_MWR;
        else return CH_CPLD;
    endfunction

endpackage

// File: rtl/ipsl_pcie_dma_tx_skid.sv
// Two-entry FIFO-ordered AXI-stream skid buffer; the head register drives the output
// directly so data stays stable while stalled.
module ipsl_pcie_dma_tx_skid #(
    parameter int unsigned WIDTH = 130
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             pop;

    assign valid_o = (count_q != 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign data_o  = head_q;
    assign pop     = valid_o & ready_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + 2'(push_i) - 2'(pop);
        unique case (count_q)
            2'd0: if (push_i) head_d = push_data_i;
            2'd1: begin
                if (push_i && pop) head_d = push_data_i;
                else if (push_i) tail_d = push_data_i;
            end
            2'd2: if (pop) head_d = tail_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Upstream trdy is gated by full_o, so a push into a full buffer is a design bug.
    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (!(push_i && full_o));
    end

endmodule

// File: rtl/ipsl_pcie_dma_tx_arb.sv
// Merges the CPLD/MRD/MWR TLP streams into one TX stream with TLP-atomic arbitration,
// a 2-entry output skid buffer and saturating per-channel TLP counters.
module ipsl_pcie_dma_tx_arb
    import ipsl_pcie_dma_tx_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 128,
    parameter int unsigned CPLD_PRIORITY = 1,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_axis_slave0_tvld,
    input  logic [DATA_WIDTH-1:0]    i_axis_slave0_tdata,
    input  logic                     i_axis_slave0_tlast,
    input  logic                     i_axis_slave0_tuser,
    output logic                     o_axis_slave0_trdy,
    input  logic                     i_axis_slave1_tvld,
    input  logic [DATA_WIDTH-1:0]    i_axis_slave1_tdata,
    input  logic                     i_axis_slave1_tlast,
    input  logic                     i_axis_slave1_tuser,
    output logic                     o_axis_slave1_trdy,
    input  logic                     i_axis_slave2_tvld,
    input  logic [DATA_WIDTH-1:0]    i_axis_slave2_tdata,
    input  logic                     i_axis_slave2_tlast,
    input  logic                     i_axis_slave2_tuser,
    output logic                     o_axis_slave2_trdy,
    output logic                     o_axis_tx_tvld,
    output logic [DATA_WIDTH-1:0]    o_axis_tx_tdata,
    output logic                     o_axis_tx_tlast,
    output logic                     o_axis_tx_tuser,
    input  logic                     i_axis_tx_trdy,
    input  logic                     i_tx_restart,
    output logic [2:0]               o_grant,
    output logic [3*CNT_WIDTH-1:0]   o_tlp_cnt
);

    logic [2:0]            tvld, tlast, tuser, trdy;
    logic [DATA_WIDTH-1:0] tdata [NUM_CH];
    logic [DATA_WIDTH+1:0] acc_beat, skid_data;
    logic                  acc, acc_last, skid_full;

    arb_state_e            state_q;
    logic [2:0]            grant_q;
    logic [1:0]            ptr_q;
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_CH];

    assign tvld     = {i_axis_slave2_tvld, i_axis_slave1_tvld, i_axis_slave0_tvld};
    assign tlast    = {i_axis_slave2_tlast, i_axis_slave1_tlast, i_axis_slave0_tlast};
    assign tuser    = {i_axis_slave2_tuser, i_axis_slave1_tuser, i_axis_slave0_tuser};
    assign tdata[0] = i_axis_slave0_tdata;
    assign tdata[1] = i_axis_slave1_tdata;
    assign tdata[2] = i_axis_slave2_tdata;

    // grant_q is zero in IDLE, so this also keeps every trdy low there.
    assign trdy = grant_q & {3{~skid_full}};
    assign {o_axis_slave2_trdy, o_axis_slave1_trdy, o_axis_slave0_trdy} = trdy;

    assign acc = |(tvld & trdy);

    always_comb begin
        acc_beat = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_q[i]) acc_beat = {tdata[i], tlast[i], tuser[i]};
        end
    end

    assign acc_last = acc & acc_beat[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= CH_CPLD;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|tvld) begin
                        grant_q <= pick_winner(tvld, ptr_q, CPLD_PRIORITY != 0);
                        state_q <= StXfer;
                    end
                end
                StXfer: begin
                    if (acc_last) begin
                        grant_q <= '0;
                        ptr_q   <= next_ptr(grant_q);
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_tx_restart) begin
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else if (acc_last) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant_q[i] && !(&cnt_q[i])) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    assign o_grant   = grant_q;
    assign o_tlp_cnt = {cnt_q[2], cnt_q[1], cnt_q[0]};

    ipsl_pcie_dma_tx_skid #(
        .WIDTH(DATA_WIDTH + 2)
    ) u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (acc),
        .push_data_i (acc_beat),
        .full_o      (skid_full),
        .valid_o     (o_axis_tx_tvld),
        .data_o      (skid_data),
        .ready_i     (i_axis_tx_trdy)
    );

    assign {o_axis_tx_tdata, o_axis_tx_tlast, o_axis_tx_tuser} = skid_data;

endmodule

// File: tb/tb_ipsl_pcie_dma_tx_arb.sv
// Self-checking bench: two arbiters (CPLD priority / 16-bit counters and round-robin /
// 2-bit counters) share stimulus; a TLP-level model predicts output order.
module tb_ipsl_pcie_dma_tx_arb;

    localparam int DW = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
    } beat_t;

    logic          clk;
    logic          rst, tx_trdy, restart;
    logic [2:0]    s_tvld, s_tlast, s_tuser;
    logic [DW-1:0] s_tdata [3];
    logic          sel;

    wire [2:0]     pr_trdy, rr_trdy, pr_grant, rr_grant;
    wire           pr_tvld, rr_tvld, pr_tlast, rr_tlast, pr_tuser, rr_tuser;
    wire [DW-1:0]  pr_tdata, rr_tdata;
    wire [47:0]    pr_cnt;
    wire [5:0]     rr_cnt;

    wire [2:0]     d_trdy  = sel ? rr_trdy : pr_trdy;
    wire           d_tvld  = sel ? rr_tvld : pr_tvld;
    wire [DW-1:0]  d_tdata = sel ? rr_tdata : pr_tdata;
    wire           d_tlast = sel ? rr_tlast : pr_tlast;
    wire           d_tuser = sel ? rr_tuser : pr_tuser;

    int    checks = 0;
    int    errors = 0;
    beat_t src_q[3][$];
    beat_t exp_q[$];
    int    first_cyc[$];
    int    ptr_m, occ, tlp_id;
    bit    out_mid;
    bit [2:0] in_mid;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ipsl_pcie_dma_tx_arb #(.DATA_WIDTH(DW), .CPLD_PRIORITY(1), .CNT_WIDTH(16)) u_pr (
        .clk(clk), .rst(rst),
        .i_axis_slave0_tvld(s_tvld[0]), .i_axis_slave0_tdata(s_tdata[0]),
        .i_axis_slave0_tlast(s_tlast[0]), .i_axis_slave0_tuser(s_tuser[0]),
        .o_axis_slave0_trdy(pr_trdy[0]),
        .i_axis_slave1_tvld(s_tvld[1]), .i_axis_slave1_tdata(s_tdata[1]),
        .i_axis_slave1_tlast(s_tlast[1]), .i_axis_slave1_tuser(s_tuser[1]),
        .o_axis_slave1_trdy(pr_trdy[1]),
        .i_axis_slave2_tvld(s_tvld[2]), .i_axis_slave2_tdata(s_tdata[2]),
        .i_axis_slave2_tlast(s_tlast[2]), .i_axis_slave2_tuser(s_tuser[2]),
        .o_axis_slave2_trdy(pr_trdy[2]),
        .o_axis_tx_tvld(pr_tvld), .o_axis_tx_tdata(pr_tdata), .o_axis_tx_tlast(pr_tlast),
        .o_axis_tx_tuser(pr_tuser), .i_axis_tx_trdy(tx_trdy), .i_tx_restart(restart),
        .o_grant(pr_grant), .o_tlp_cnt(pr_cnt)
    );

    ipsl_pcie_dma_tx_arb #(.DATA_WIDTH(DW), .CPLD_PRIORITY(0), .CNT_WIDTH(2)) u_rr (
        .clk(clk), .rst(rst),
        .i_axis_slave0_tvld(s_tvld[0]), .i_axis_slave0_tdata(s_tdata[0]),
        .i_axis_slave0_tlast(s_tlast[0]), .i_axis_slave0_tuser(s_tuser[0]),
        .o_axis_slave0_trdy(rr_trdy[0]),
        .i_axis_slave1_tvld(s_tvld[1]), .i_axis_slave1_tdata(s_tdata[1]),
        .i_axis_slave1_tlast(s_tlast[1]), .i_axis_slave1_tuser(s_tuser[1]),
        .o_axis_slave1_trdy(rr_trdy[1]),
        .i_axis_slave2_tvld(s_tvld[2]), .i_axis_slave2_tdata(s_tdata[2]),
        .i_axis_slave2_tlast(s_tlast[2]), .i_axis_slave2_tuser(s_tuser[2]),
        .o_axis_slave2_trdy(rr_trdy[2]),
        .o_axis_tx_tvld(rr_tvld), .o_axis_tx_tdata(rr_tdata), .o_axis_tx_tlast(rr_tlast),
        .o_axis_tx_tuser(rr_tuser), .i_axis_tx_trdy(tx_trdy), .i_tx_restart(restart),
        .o_grant(rr_grant), .o_tlp_cnt(rr_cnt)
    );

    task automatic add_tlp(input int ch, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom, $urandom, 8'(ch), 8'(tlp_id), 16'(i)};
            b.last = (i == len - 1);
            b.user = 1'($urandom);
            src_q[ch].push_back(b);
        end
        tlp_id++;
    endtask

    // Whole-TLP order, assuming every queued channel requests at each arbitration point.
    task automatic build_expected(input bit prio);
        int pos[3];
        int w, c;
        pos = '{0, 0, 0};
        forever begin
            w = -1;
            if (prio && pos[0] < src_q[0].size()) w = 0;
            else begin
                for (int k = 0; k < 3; k++) begin
                    c = (ptr_m + k) % 3;
                    if (w < 0 && pos[c] < src_q[c].size()) w = c;
                end
            end
            if (w < 0) break;
            do begin
                exp_q.push_back(src_q[w][pos[w]]);
                pos[w]++;
            end while (!src_q[w][pos[w] - 1].last);
            ptr_m = (w + 1) % 3;
        end
    endtask

    task automatic drive_inputs(input int gap_pct);
        for (int ch = 0; ch < 3; ch++) begin
            if (src_q[ch].size() == 0) begin
                s_tvld[ch]  = 1'b0;
                s_tlast[ch] = 1'b0;
            end else begin
                s_tdata[ch] = src_q[ch][0].data;
                s_tlast[ch] = src_q[ch][0].last;
                s_tuser[ch] = src_q[ch][0].user;
                s_tvld[ch]  = !in_mid[ch] || (int'($urandom_range(99)) >= gap_pct);
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; restart = 1'b0; tx_trdy = 1'b1; s_tvld = '0;
        for (int ch = 0; ch < 3; ch++) src_q[ch].delete();
        exp_q.delete();
        first_cyc.delete();
        occ = 0; out_mid = 0; in_mid = '0; ptr_m = 0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run(input bit which, input int gap_pct, input int bp_mode,
                       input int stop_in, input int budget);
        int    cyc = 0;
        int    nin = 0;
        bit [2:0] fire;
        bit    ofire;
        beat_t got, want;
        sel = which;
        build_expected(which == 1'b0);
        drive_inputs(gap_pct);
        tx_trdy = (bp_mode == 2) ? 1'($urandom) : 1'b1;
        forever begin
            @(negedge clk);
            checks++;
            if (d_tvld !== (occ != 0)) begin
                errors++;
                $display("FAIL out_valid cyc=%0d got=%b want=%b", cyc, d_tvld, occ != 0);
            end
            if (occ == 2) begin
                checks++;
                if (d_trdy !== 3'b000) begin
                    errors++;
                    $display("FAIL trdy_when_full cyc=%0d got=%b want=000", cyc, d_trdy);
                end
            end
            fire  = s_tvld & d_trdy;
            ofire = d_tvld && tx_trdy;
            if (ofire) begin
                got = {d_tdata, d_tlast, d_tuser};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat cyc=%0d got=%h want=none", cyc, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("FAIL out_beat cyc=%0d got=%h want=%h", cyc, got, want);
                    end
                end
                if (!out_mid) first_cyc.push_back(cyc);
                out_mid = !d_tlast;
            end
            @(posedge clk);
            #1;
            cyc++;
            occ = occ + $countones(fire) - int'(ofire);
            for (int ch = 0; ch < 3; ch++) begin
                if (fire[ch]) begin
                    in_mid[ch] = !src_q[ch][0].last;
                    void'(src_q[ch].pop_front());
                    nin++;
                end
            end
            if (stop_in != 0 && nin >= stop_in) return;
            drive_inputs(gap_pct);
            case (bp_mode)
                0:       tx_trdy = 1'b1;
                1:       tx_trdy = (cyc % 3 == 0);
                default: tx_trdy = 1'($urandom);
            endcase
            if (exp_q.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                src_q[2].size() == 0) break;
            if (cyc >= budget) begin
                checks++;
                errors++;
                $display("FAIL timeout cyc=%0d got=%0d_beats_left want=0", cyc, exp_q.size());
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; restart = 1'b0; tx_trdy = 1'b1; sel = 1'b0;
        s_tvld = 3'b111; s_tlast = 3'b000; s_tuser = 3'b111;
        for (int ch = 0; ch < 3; ch++) s_tdata[ch] = {4{$urandom}};
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pr_trdy, rr_trdy} !== 6'b0) begin
            errors++; $display("FAIL reset_trdy got=%b%b want=0", pr_trdy, rr_trdy);
        end
        checks++;
        if ({pr_tvld, rr_tvld, pr_tlast, rr_tlast, pr_tuser, rr_tuser} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b%b want=0", pr_tvld, rr_tvld);
        end
        checks++;
        if ({pr_tdata, rr_tdata} !== '0) begin
            errors++; $display("FAIL reset_tdata got=%h want=0", pr_tdata);
        end
        checks++;
        if ({pr_grant, rr_grant} !== 6'b0) begin
            errors++; $display("FAIL reset_grant got=%b%b want=0", pr_grant, rr_grant);
        end
        checks++;
        if ({pr_cnt, rr_cnt} !== '0) begin
            errors++; $display("FAIL reset_cnt got=%h %h want=0", pr_cnt, rr_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pr_grant !== 3'b001 || rr_grant !== 3'b001) begin
            errors++; $display("FAIL first_grant got=%b %b want=001", pr_grant, rr_grant);
        end
    endtask

    task automatic test_round_robin();
        do_reset(2);
        for (int t = 0; t < 2; t++) for (int ch = 0; ch < 3; ch++) add_tlp(ch, 4);
        run(1'b1, 0, 0, 0, 500);
        checks++;
        if (first_cyc.size() != 6) begin
            errors++; $display("FAIL rr_tlp_count got=%0d want=6", first_cyc.size());
        end else begin
            for (int i = 1; i < 6; i++) begin
                checks++;
                if (first_cyc[i] - first_cyc[i-1] != 5) begin
                    errors++;
                    $display("FAIL rr_spacing tlp=%0d got=%0d want=5", i,
                             first_cyc[i] - first_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_priority();
        do_reset(2);
        for (int t = 0; t < 4; t++) add_tlp(0, 3);
        for (int t = 0; t < 2; t++) add_tlp(2, 2);
        run(1'b0, 0, 0, 0, 500);
    endtask

    task automatic test_backpressure();
        do_reset(2);
        add_tlp(2, 8);
        run(1'b0, 0, 1, 0, 200);
    endtask

    task automatic test_counters();
        bit hit = 0;
        do_reset(2);
        for (int t = 0; t < 3; t++) add_tlp(0, int'($urandom_range(3, 1)));
        run(1'b0, 0, 2, 0, 300);
        checks++;
        if (pr_cnt !== 48'd3) begin
            errors++; $display("FAIL cnt_three got=%h want=3", pr_cnt);
        end
        s_tvld[0] = 1'b1; s_tlast[0] = 1'b1; s_tdata[0] = {4{$urandom}}; tx_trdy = 1'b1;
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (pr_trdy[0]) begin
                restart = 1'b1;
                hit     = 1;
            end
            @(posedge clk);
            #1 restart = 1'b0;
            if (hit) s_tvld[0] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (!hit || pr_cnt !== 48'd0) begin
            errors++; $display("FAIL cnt_restart got=%h hit=%0d want=0", pr_cnt, hit);
        end
        do_reset(2);
        for (int t = 0; t < 5; t++) add_tlp(0, 2);
        run(1'b1, 0, 0, 0, 300);
        checks++;
        if (rr_cnt !== 6'd3) begin
            errors++; $display("FAIL cnt_saturate got=%h want=3", rr_cnt);
        end
    endtask

    task automatic test_reset_mid_tlp();
        do_reset(2);
        add_tlp(1, 4);
        run(1'b0, 0, 0, 2, 50);
        rst = 1'b1;
        s_tvld = '0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pr_tvld !== 1'b0 || pr_grant !== 3'b000) begin
            errors++; $display("FAIL mid_reset got=%b/%b want=0/000", pr_tvld, pr_grant);
        end
        do_reset(2);
        add_tlp(1, 4);
        run(1'b0, 0, 0, 0, 100);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            do_reset(2);
            for (int ch = 0; ch < 3; ch++) begin
                for (int t = 0; t < int'($urandom_range(3, 0)); t++) begin
                    add_tlp(ch, int'($urandom_range(6, 1)));
                end
            end
            run(1'(it % 2), 30, 2, 0, 2000);
        end
    endtask

    initial begin
        tlp_id = 0;
        test_reset();
        test_round_robin();
        test_priority();
        test_backpressure();
        test_counters();
        test_reset_mid_tlp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
